// File: rtl/multi_key_debounce.sv
// N-channel active-low key debouncer with 2-FF synchronisers, press/release pulses and key_any strobe.
// Define KEY_LONGPRESS_EN to build per-channel hold counters driving key_long.
module multi_key_debounce #(
  parameter int unsigned N_KEYS           = 4,
  parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
  parameter int unsigned LONGPRESS_CYCLES = 50_000_000
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic              key_any
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [CNT_W-1:0]  cnt [N_KEYS];
  logic [N_KEYS-1:0] accept;
  logic [N_KEYS-1:0] press_nxt;
  logic [N_KEYS-1:0] release_nxt;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  // A channel accepts its new level on the edge where the mismatch has lasted the full count.
  always_comb begin
    accept      = '0;
    press_nxt   = '0;
    release_nxt = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      accept[i]      = (sync2[i] != key_state[i]) && (cnt[i] == CNT_MAX);
      press_nxt[i]   = accept[i] && !sync2[i];
      release_nxt[i] = accept[i] &&  sync2[i];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      key_state   <= '1;
      key_press   <= '0;
      key_release <= '0;
      key_any     <= 1'b0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_any     <= |press_nxt;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (sync2[i] == key_state[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cnt[i]       <= '0;
          key_state[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef KEY_LONGPRESS_EN
  localparam int unsigned       HOLD_W   = $clog2(LONGPRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONGPRESS_CYCLES);

  logic [HOLD_W-1:0] hold [N_KEYS];
  logic [N_KEYS-1:0] long_q;

  // Saturation at HOLD_MAX is what limits key_long to one pulse per press.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      long_q <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        long_q[i] <= 1'b0;
        if (key_state[i]) begin
          hold[i] <= '0;
        end else if (hold[i] != HOLD_MAX) begin
          hold[i]   <= hold[i] + 1'b1;
          long_q[i] <= (hold[i] == HOLD_MAX - 1'b1);
        end
      end
    end
  end

  assign key_long = long_q;
`else
  logic [31:0] unused_longpress_cycles;
  assign unused_longpress_cycles = 32'(LONGPRESS_CYCLES);
  assign key_long = '0;
`endif

endmodule

// File: tb/tb_multi_key_debounce.sv
// Directed self-checking bench for multi_key_debounce (N_KEYS=4, DEBOUNCE_CYCLES=16, LONGPRESS_CYCLES=64).
module tb_multi_key_debounce;
  localparam int unsigned N = 4;
  localparam int unsigned D = 16;
  localparam int unsigned L = 64;
`ifdef KEY_LONGPRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic         sys_clk = 1'b0;
  logic         rst_n   = 1'b0;
  logic [N-1:0] key_in  = '1;
  logic [N-1:0] key_state;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] key_long;
  logic         key_any;

  int checks   = 0;
  int failures = 0;

  multi_key_debounce #(
    .N_KEYS          (N),
    .DEBOUNCE_CYCLES (D),
    .LONGPRESS_CYCLES(L)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_any    (key_any)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    key_in = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      if (k == 6) rst_n = 1'b1;
      step();
      checks++;
      if (key_state !== 4'hF) begin
        failures++;
        $display("FAIL reset_state k=%0d got=%b exp=%b", k, key_state, 4'hF);
      end
      checks++;
      if (key_press !== 4'h0 || key_release !== 4'h0 || key_long !== 4'h0 || key_any !== 1'b0) begin
        failures++;
        $display("FAIL reset_pulses k=%0d got press=%b rel=%b long=%b any=%b exp all 0",
                 k, key_press, key_release, key_long, key_any);
      end
    end
  endtask

  task automatic test_press();
    logic [N-1:0] exp_p, exp_s;
    key_in = 4'b1110;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_p = (k == 18) ? 4'b0001 : 4'b0000;
      exp_s = (k >= 18) ? 4'b1110 : 4'b1111;
      checks++;
      if (key_press !== exp_p) begin
        failures++;
        $display("FAIL press_pulse k=%0d got=%b exp=%b", k, key_press, exp_p);
      end
      checks++;
      if (key_state !== exp_s) begin
        failures++;
        $display("FAIL press_state k=%0d got=%b exp=%b", k, key_state, exp_s);
      end
      checks++;
      if (key_any !== (k == 18)) begin
        failures++;
        $display("FAIL press_any k=%0d got=%b exp=%b", k, key_any, (k == 18));
      end
      checks++;
      if (key_release !== 4'b0000) begin
        failures++;
        $display("FAIL press_release k=%0d got=%b exp=0000", k, key_release);
      end
    end
  endtask

  task automatic test_glitch();
    logic [N-1:0] exp_r;
    for (int t = 0; t < 120; t++) begin
      key_in[1] = (t < 100) ? (((t / 5) % 2) != 0) : 1'b1;
      step();
      checks++;
      if (key_state !== 4'b1110 || key_press !== 4'b0000 || key_release !== 4'b0000) begin
        failures++;
        $display("FAIL glitch t=%0d got state=%b press=%b rel=%b exp state=1110 no pulses",
                 t, key_state, key_press, key_release);
      end
    end
    key_in = 4'hF;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_r = (k == 18) ? 4'b0001 : 4'b0000;
      checks++;
      if (key_release !== exp_r || key_press !== 4'b0000) begin
        failures++;
        $display("FAIL release_key0 k=%0d got rel=%b press=%b exp rel=%b press=0000",
                 k, key_release, key_press, exp_r);
      end
    end
  endtask

  task automatic test_two_keys();
    logic [N-1:0] exp_p, exp_r, exp_s;
    key_in = 4'b0011;
    for (int k = 1; k <= 40; k++) begin
      step();
      exp_p = (k == 18) ? 4'b1100 : 4'b0000;
      checks++;
      if (key_press !== exp_p || key_any !== (k == 18)) begin
        failures++;
        $display("FAIL two_press k=%0d got press=%b any=%b exp press=%b any=%b",
                 k, key_press, key_any, exp_p, (k == 18));
      end
      checks++;
      if (key_release !== 4'b0000 || key_long !== 4'b0000) begin
        failures++;
        $display("FAIL two_hold k=%0d got rel=%b long=%b exp 0000", k, key_release, key_long);
      end
    end
    key_in = 4'hF;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_r = (k == 18) ? 4'b1100 : 4'b0000;
      exp_s = (k >= 18) ? 4'b1111 : 4'b0011;
      checks++;
      if (key_release !== exp_r || key_press !== 4'b0000 || key_any !== 1'b0) begin
        failures++;
        $display("FAIL two_release k=%0d got rel=%b press=%b any=%b exp rel=%b",
                 k, key_release, key_press, key_any, exp_r);
      end
      checks++;
      if (key_state !== exp_s) begin
        failures++;
        $display("FAIL two_state k=%0d got=%b exp=%b", k, key_state, exp_s);
      end
    end
  endtask

  task automatic test_longpress();
    logic [N-1:0] exp_l, exp_r;
    key_in = 4'b1110;
    for (int k = 1; k <= 18; k++) step();
    checks++;
    if (key_press !== 4'b0001) begin
      failures++;
      $display("FAIL long_press got=%b exp=0001", key_press);
    end
    for (int m = 1; m <= 182; m++) begin
      step();
      exp_l = (LP_EN && m == 64) ? 4'b0001 : 4'b0000;
      checks++;
      if (key_long !== exp_l) begin
        failures++;
        $display("FAIL long_pulse m=%0d got=%b exp=%b", m, key_long, exp_l);
      end
    end
    key_in = 4'hF;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_r = (k == 18) ? 4'b0001 : 4'b0000;
      checks++;
      if (key_release !== exp_r || key_long !== 4'b0000) begin
        failures++;
        $display("FAIL long_release k=%0d got rel=%b long=%b exp rel=%b long=0000",
                 k, key_release, key_long, exp_r);
      end
    end
    key_in = 4'b1110;
    for (int k = 1; k <= 80; k++) begin
      if (k == 51) key_in = 4'hF;
      step();
      checks++;
      if (key_long !== 4'b0000) begin
        failures++;
        $display("FAIL short_hold k=%0d got long=%b exp=0000", k, key_long);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] exp_p, exp_s;
    key_in = 4'b1110;
    for (int k = 1; k <= 10; k++) step();
    rst_n = 1'b0;
    step();
    checks++;
    if (key_state !== 4'hF || key_press !== 4'h0 || key_release !== 4'h0 || key_any !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got state=%b press=%b rel=%b any=%b exp state=1111 no pulses",
               key_state, key_press, key_release, key_any);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_p = (k == 18) ? 4'b0001 : 4'b0000;
      exp_s = (k >= 18) ? 4'b1110 : 4'b1111;
      checks++;
      if (key_press !== exp_p || key_any !== (k == 18)) begin
        failures++;
        $display("FAIL reacquire_press k=%0d got press=%b any=%b exp press=%b",
                 k, key_press, key_any, exp_p);
      end
      checks++;
      if (key_state !== exp_s) begin
        failures++;
        $display("FAIL reacquire_state k=%0d got=%b exp=%b", k, key_state, exp_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_two_keys();
    test_longpress();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
